johnson_phase_monitor: RTL and testbench

Decodes and checks the 4-bit Johnson count stream produced by the down-counter stage. Maps each sample to a 3-bit phase index and verifies that legal codes follow a hold-or-advance sequence. Tracks lock status, full-cycle wraps and errors. Sits directly downstream of the Johnson counter and feeds status and phase to the display/control logic.

---
 rtl/johnson_pkg.sv | 13 +
 rtl/johnson_decode.sv | 24 ++
 rtl/johnson_phase_monitor.sv | 98 +++++++++
 tb/tb_johnson_phase_monitor.sv | 89 ++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: state encoding, legal Johnson codes and lock default shared by the phase monitor.
package johnson_pkg;
  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;
  localparam logic [3:0] J0 = 4'b0000;
  localparam logic [3:0] J1 = 4'b1000;
  localparam logic [3:0] J2 = 4'b1100;
  localparam logic [3:0] J3 = 4'b1110;
  localparam logic [3:0] J4 = 4'b1111;
  localparam logic [3:0] J5 = 4'b0111;
  localparam logic [3:0] J6 = 4'b0011;
  localparam logic [3:0] J7 = 4'b0001;
  localparam int DEF_LOCK_COUNT = 4;
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational map from a 4-bit Johnson code to a phase index plus legal flag.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [2:0] o_phase,
  output logic       o_legal
);
  always_comb begin
    o_phase = 3'd0;
    o_legal = 1'b1;
    case (i_code)
      J0: o_phase = 3'd0;
      J1: o_phase = 3'd1;
      J2: o_phase = 3'd2;
      J3: o_phase = 3'd3;
      J4: o_phase = 3'd4;
      J5: o_phase = 3'd5;
      J6: o_phase = 3'd6;
      J7: o_phase = 3'd7;
      default: o_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: decodes the Johnson stream, checks hold/advance sequencing and tracks lock, wraps and errors.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int WRAP_WIDTH = 8,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            johnson_in,
  output logic [2:0]            phase,
  output logic                  phase_valid,
  output logic                  locked,
  output logic                  illegal_code,
  output logic                  step_error,
  output logic                  wrap_pulse,
  output logic [WRAP_WIDTH-1:0] wrap_count,
  output logic [ERR_WIDTH-1:0]  err_count
);
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_good_cnt, w_good_nxt, w_good_inc;
  logic [2:0]            r_phase, w_d;
  logic                  r_valid, r_illegal, r_step, r_wrap;
  logic [WRAP_WIDTH-1:0] r_wrap_count;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic                  w_legal, w_hold, w_adv, w_step, w_wrap;

  johnson_decode u_decode (.i_code(johnson_in), .o_phase(w_d), .o_legal(w_legal));

  assign w_hold     = w_legal && (w_d == r_phase);
  assign w_adv      = w_legal && (w_d == r_phase + 3'd1);
  assign w_step     = w_legal && (r_state != ACQUIRE) && !w_hold && !w_adv;
  // A wrap only counts when the stream was already locked before this edge.
  assign w_wrap     = (r_state == LOCKED) && w_adv && (r_phase == 3'd7);
  assign w_good_inc = r_good_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    if (!w_legal) begin
      w_state_nxt = ACQUIRE;
      w_good_nxt  = 4'd0;
    end else begin
      case (r_state)
        ACQUIRE: begin
          w_state_nxt = TRACK;
          w_good_nxt  = 4'd0;
        end
        TRACK: begin
          w_good_nxt  = w_adv ? w_good_inc : (w_hold ? r_good_cnt : 4'd0);
          w_state_nxt = (w_adv && w_good_inc == 4'(LOCK_COUNT)) ? LOCKED : TRACK;
        end
        LOCKED: begin
          w_state_nxt = w_step ? TRACK : LOCKED;
          w_good_nxt  = w_step ? 4'd0 : r_good_cnt;
        end
        default: begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ACQUIRE;
      r_good_cnt   <= 4'd0;
      r_phase      <= 3'd0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_step       <= 1'b0;
      r_wrap       <= 1'b0;
      r_wrap_count <= '0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_good_cnt   <= w_good_nxt;
      r_phase      <= w_legal ? w_d : r_phase;
      r_valid      <= w_legal;
      r_illegal    <= !w_legal;
      r_step       <= w_step;
      r_wrap       <= w_wrap;
      r_wrap_count <= r_wrap_count + WRAP_WIDTH'(w_wrap);
      r_err_count  <= ((!w_legal || w_step) && !(&r_err_count)) ? r_err_count + ERR_WIDTH'(1) : r_err_count;
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_valid;
  assign locked       = (r_state == LOCKED);
  assign illegal_code = r_illegal;
  assign step_error   = r_step;
  assign wrap_pulse   = r_wrap;
  assign wrap_count   = r_wrap_count;
  assign err_count    = r_err_count;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: directed vectors with hand-computed expectations for the Johnson phase monitor.
module tb_johnson_phase_monitor;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] johnson_in;
  logic [2:0] phase;
  logic       phase_valid, locked, illegal_code, step_error, wrap_pulse;
  logic [7:0] wrap_count;
  logic [1:0] err_count;
  int         n_checks = 0;
  int         n_errors = 0;

  johnson_phase_monitor #(.LOCK_COUNT(4), .WRAP_WIDTH(8), .ERR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .johnson_in(johnson_in), .phase(phase),
    .phase_valid(phase_valid), .locked(locked), .illegal_code(illegal_code),
    .step_error(step_error), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] ph, input logic pv, input logic lk,
                            input logic ill, input logic se, input logic wp,
                            input logic [7:0] wc, input logic [1:0] ec);
    check({tag, ".phase"}, 16'(phase), 16'(ph));
    check({tag, ".valid"}, 16'(phase_valid), 16'(pv));
    check({tag, ".locked"}, 16'(locked), 16'(lk));
    check({tag, ".illegal"}, 16'(illegal_code), 16'(ill));
    check({tag, ".step"}, 16'(step_error), 16'(se));
    check({tag, ".wrap"}, 16'(wrap_pulse), 16'(wp));
    check({tag, ".wrap_cnt"}, 16'(wrap_count), 16'(wc));
    check({tag, ".err_cnt"}, 16'(err_count), 16'(ec));
  endtask

  task automatic drive(input logic [3:0] code, input logic rst);
    @(negedge clk);
    johnson_in = code;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    johnson_in = 4'b0000;
    drive(4'b0000, 1'b1);
    expect_out("reset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b0000, 1'b0); expect_out("lock0", 3'd0, 1, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1000, 1'b0); expect_out("lock1", 3'd1, 1, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1100, 1'b0); expect_out("lock2", 3'd2, 1, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1110, 1'b0); expect_out("lock3", 3'd3, 1, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1111, 1'b0); expect_out("lock4", 3'd4, 1, 1, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b0111, 1'b0); expect_out("wrap5", 3'd5, 1, 1, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b0011, 1'b0); expect_out("wrap6", 3'd6, 1, 1, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b0001, 1'b0); expect_out("wrap7", 3'd7, 1, 1, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b0000, 1'b0); expect_out("wrap0", 3'd0, 1, 1, 0, 0, 1, 8'd1, 2'd0);
    drive(4'b1000, 1'b0); expect_out("adv1", 3'd1, 1, 1, 0, 0, 0, 8'd1, 2'd0);
    drive(4'b1100, 1'b0); expect_out("adv2", 3'd2, 1, 1, 0, 0, 0, 8'd1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1100, 1'b0); expect_out("hold", 3'd2, 1, 1, 0, 0, 0, 8'd1, 2'd0);
    end
    drive(4'b1111, 1'b0); expect_out("step", 3'd4, 1, 0, 0, 1, 0, 8'd1, 2'd1);
    drive(4'b0111, 1'b0); expect_out("relock5", 3'd5, 1, 0, 0, 0, 0, 8'd1, 2'd1);
    drive(4'b0011, 1'b0); expect_out("relock6", 3'd6, 1, 0, 0, 0, 0, 8'd1, 2'd1);
    drive(4'b0001, 1'b0); expect_out("relock7", 3'd7, 1, 0, 0, 0, 0, 8'd1, 2'd1);
    drive(4'b0000, 1'b0); expect_out("relock0", 3'd0, 1, 1, 0, 0, 0, 8'd1, 2'd1);
    drive(4'b1010, 1'b0); expect_out("illegal", 3'd0, 0, 0, 1, 0, 0, 8'd1, 2'd2);
    drive(4'b0011, 1'b0); expect_out("acquire", 3'd6, 1, 0, 0, 0, 0, 8'd1, 2'd2);
    drive(4'b1010, 1'b0); expect_out("sat1", 3'd6, 0, 0, 1, 0, 0, 8'd1, 2'd3);
    drive(4'b0101, 1'b0); expect_out("sat2", 3'd6, 0, 0, 1, 0, 0, 8'd1, 2'd3);
    drive(4'b1001, 1'b0); expect_out("sat3", 3'd6, 0, 0, 1, 0, 0, 8'd1, 2'd3);
    drive(4'b1000, 1'b1); expect_out("midreset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1100, 1'b0); expect_out("postreset", 3'd2, 1, 0, 0, 0, 0, 8'd0, 2'd0);
    drive(4'b1010, 1'b0); expect_out("ill1", 3'd2, 0, 0, 1, 0, 0, 8'd0, 2'd1);
    drive(4'b1011, 1'b0); expect_out("ill2", 3'd2, 0, 0, 1, 0, 0, 8'd0, 2'd2);
    drive(4'b0100, 1'b0); expect_out("ill3", 3'd2, 0, 0, 1, 0, 0, 8'd0, 2'd3);
    drive(4'b1101, 1'b0); expect_out("ill4", 3'd2, 0, 0, 1, 0, 0, 8'd0, 2'd3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
